// File: rtl/clk_gate_ctrl_pkg.sv
// Shared types and sizing helpers for the per-domain clock-gating controller.
package clk_gate_ctrl_pkg;

    typedef enum logic [1:0] {
        CG_OFF  = 2'd0,
        CG_WAKE = 2'd1,
        CG_ON   = 2'd2,
        CG_IDLE = 2'd3
    } cg_state_e;

    // One counter serves both the wake and idle phases, so size it for the larger.
    function automatic int cg_cnt_width(input int wake, input int idle);
        int m;
        int w;
        m = (wake > idle) ? wake : idle;
        w = $clog2(m + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/clk_gate_ctrl_fsm.sv
// Single-domain wake/idle sequencer with registered gate enable and acknowledge.
//
// state   | meaning
// --------+--------------------------------------------------------
// CG_OFF  | clock gated, waiting for req or force_on
// CG_WAKE | gate enabled, counting settling cycles before ack
// CG_ON   | clock running and acknowledged
// CG_IDLE | no keep, clock still running, counting hysteresis
module clk_gate_ctrl_fsm
    import clk_gate_ctrl_pkg::*;
#(
    parameter int WAKE_CYCLES = 2,
    parameter int IDLE_CYCLES = 16,
    parameter int CNT_W       = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic req,
    input  logic busy,
    input  logic force_on,
    output logic en,
    output logic ack,
    output logic off
);

    localparam logic [CNT_W-1:0] WAKE_LOAD = CNT_W'((WAKE_CYCLES > 0) ? WAKE_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] IDLE_LOAD = CNT_W'((IDLE_CYCLES > 0) ? IDLE_CYCLES - 1 : 0);

    cg_state_e        state;
    logic [CNT_W-1:0] cnt;
    logic             keep;
    logic             wake;

    assign keep = req | busy | force_on;
    assign wake = req | force_on;
    assign off  = (state == CG_OFF);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= CG_OFF;
            cnt   <= '0;
            en    <= 1'b0;
            ack   <= 1'b0;
        end else begin
            case (state)
                CG_OFF: begin
                    if (wake) begin
                        en <= 1'b1;
                        if (WAKE_CYCLES > 0) begin
                            state <= CG_WAKE;
                            cnt   <= WAKE_LOAD;
                        end else begin
                            state <= CG_ON;
                            ack   <= 1'b1;
                        end
                    end
                end
                // A dropped request does not abort the wake; the domain settles first.
                CG_WAKE: begin
                    if (cnt == '0) begin
                        state <= CG_ON;
                        ack   <= 1'b1;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                CG_ON: begin
                    if (!keep) begin
                        if (IDLE_CYCLES > 0) begin
                            state <= CG_IDLE;
                            cnt   <= IDLE_LOAD;
                        end else begin
                            state <= CG_OFF;
                            en    <= 1'b0;
                            ack   <= 1'b0;
                        end
                    end
                end
                CG_IDLE: begin
                    if (keep) begin
                        state <= CG_ON;
                    end else if (cnt == '0) begin
                        state <= CG_OFF;
                        en    <= 1'b0;
                        ack   <= 1'b0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state <= CG_OFF;
                    en    <= 1'b0;
                    ack   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/clk_gate_ctrl.sv
// Per-domain clock-gating controller: one sequencer per domain, test-mode
// bypass on the enables, and a registered all-domains-gated flag.
module clk_gate_ctrl
    import clk_gate_ctrl_pkg::*;
#(
    parameter int NUM_DOMAINS = 4,
    parameter int WAKE_CYCLES = 2,
    parameter int IDLE_CYCLES = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   test_en_i,
    input  logic [NUM_DOMAINS-1:0] req_i,
    input  logic [NUM_DOMAINS-1:0] busy_i,
    input  logic [NUM_DOMAINS-1:0] force_on_i,
    output logic [NUM_DOMAINS-1:0] clk_en_o,
    output logic [NUM_DOMAINS-1:0] ack_o,
    output logic                   all_gated_o
);

    localparam int CNT_W = cg_cnt_width(WAKE_CYCLES, IDLE_CYCLES);

    logic [NUM_DOMAINS-1:0] en_q;
    logic [NUM_DOMAINS-1:0] off;

    for (genvar i = 0; i < NUM_DOMAINS; i++) begin : g_dom
        clk_gate_ctrl_fsm #(
            .WAKE_CYCLES (WAKE_CYCLES),
            .IDLE_CYCLES (IDLE_CYCLES),
            .CNT_W       (CNT_W)
        ) u_fsm (
            .clk      (clk_i),
            .rst      (rst_i),
            .req      (req_i[i]),
            .busy     (busy_i[i]),
            .force_on (force_on_i[i]),
            .en       (en_q[i]),
            .ack      (ack_o[i]),
            .off      (off[i])
        );
    end

    // Test mode bypasses the sequencers without disturbing their state.
    assign clk_en_o = en_q | {NUM_DOMAINS{test_en_i}};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            all_gated_o <= 1'b1;
        end else begin
            all_gated_o <= &off;
        end
    end

endmodule
